// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader
//   Feeds simple_generic_matrix_mult from a single valid/ready element stream.
//   Each job is A (M*N elements, row-major) followed by B (N*P elements,
//   row-major). Every accepted element goes to the multiplier's A or B memory
//   through a registered write port. Once B is complete, the loader runs the
//   multiplier's start/done handshake and then re-arms for the next job.
//
//   Optional feature macro: LOADER_LAST_CHECK_EN
//     When it is defined, an s_last input is added and frames are checked.
//     s_last must be high on the final B element and low on every other element.
//     A framing violation sets the sticky err flag, still writes the offending
//     element, and sends the loader back to LOAD_A to resync on a new job.
//     When it is undefined, framing is by count only and err is always 0.
module matrix_operand_loader #(
    parameter int M          = 3,
    parameter int N          = 3,
    parameter int P          = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [DATA_WIDTH-1:0]   s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
`ifdef LOADER_LAST_CHECK_EN
    input  logic                           s_last,
`endif
    output logic signed [DATA_WIDTH-1:0]   a_in,
    output logic [$clog2(M*N)-1:0]         a_addr,
    output logic                           a_wen,
    output logic signed [DATA_WIDTH-1:0]   b_in,
    output logic [$clog2(N*P)-1:0]         b_addr,
    output logic                           b_wen,
    output logic                           mm_start,
    input  logic                           mm_done,
    output logic                           busy,
    output logic [15:0]                    job_count,
    output logic                           err
);

    localparam int A_AW  = $clog2(M*N);
    localparam int B_AW  = $clog2(N*P);
    localparam int IDX_W = (A_AW > B_AW) ? A_AW : B_AW;

    localparam logic [IDX_W-1:0] A_LAST = IDX_W'(M*N - 1);
    localparam logic [IDX_W-1:0] B_LAST = IDX_W'(N*P - 1);

    typedef enum logic [2:0] {
        LOAD_A    = 3'd0,
        LOAD_B    = 3'd1,
        SETTLE    = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4,
        RELEASE   = 3'd5
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             xfer;
    logic             frame_bad;

    assign s_ready = (state == LOAD_A) || (state == LOAD_B);
    assign busy    = (state != LOAD_A);
    assign xfer    = s_valid && s_ready;

    // Framing check: s_last must be high exactly on the final B element.
`ifdef LOADER_LAST_CHECK_EN
    logic last_expected;
    assign last_expected = (state == LOAD_B) && (idx == B_LAST);
    assign frame_bad     = (s_last != last_expected);
`else
    assign frame_bad     = 1'b0;
`endif

    // Job sequencer: address counting, registered write ports, multiplier handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD_A;
            idx       <= '0;
            a_in      <= '0;
            a_addr    <= '0;
            a_wen     <= 1'b0;
            b_in      <= '0;
            b_addr    <= '0;
            b_wen     <= 1'b0;
            mm_start  <= 1'b0;
            job_count <= '0;
            err       <= 1'b0;
        end else begin
            // Write enables are single-cycle pulses by default.
            a_wen <= 1'b0;
            b_wen <= 1'b0;
            case (state)
                LOAD_A: begin
                    if (xfer) begin
                        a_wen  <= 1'b1;
                        a_in   <= s_data;
                        a_addr <= idx[A_AW-1:0];
                        if (frame_bad) begin
                            err <= 1'b1;
                            idx <= '0;
                        end else if (idx == A_LAST) begin
                            idx   <= '0;
                            state <= LOAD_B;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        b_wen  <= 1'b1;
                        b_in   <= s_data;
                        b_addr <= idx[B_AW-1:0];
                        if (frame_bad) begin
                            // Bad frame: drop the job and resync on the next A.
                            err   <= 1'b1;
                            idx   <= '0;
                            state <= LOAD_A;
                        end else if (idx == B_LAST) begin
                            idx   <= '0;
                            state <= SETTLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    // Give the final b_wen one cycle to land before start.
                    state <= START;
                end
                START: begin
                    mm_start <= 1'b1;
                    state    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (mm_done) begin
                        mm_start  <= 1'b0;
                        job_count <= job_count + 16'd1;
                        state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Wait until the multiplier has returned to idle.
                    if (!mm_done) begin
                        state <= LOAD_A;
                    end
                end
                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb_matrix_operand_loader
//   Directed and randomized jobs for matrix_operand_loader.
//   A small behavioural multiplier captures the a/b memory writes and answers
//   the start/done handshake. Results are compared against a matrix product
//   that the bench computes from the elements it sent.
module tb_matrix_operand_loader;

    localparam int M  = 3;
    localparam int N  = 3;
    localparam int P  = 3;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic [DW-1:0] a_in;
    logic [3:0]    a_addr;
    logic          a_wen;
    logic [DW-1:0] b_in;
    logic [3:0]    b_addr;
    logic          b_wen;
    logic          mm_start;
    logic          mm_done;
    logic          busy;
    logic [15:0]   job_count;
    logic          err;

    int checks = 0;
    int errors = 0;
    int exp_jobs = 0;

    logic [DW-1:0] ja [9];
    logic [DW-1:0] jb [9];
    logic [DW-1:0] cap_a [9];
    logic [DW-1:0] cap_b [9];
    logic [15:0]   mult_c [9];
    logic [12:0]   exp_q [$];

    matrix_operand_loader #(.M(M), .N(N), .P(P), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
`ifdef LOADER_LAST_CHECK_EN
        .s_last    (s_last),
`endif
        .a_in      (a_in),
        .a_addr    (a_addr),
        .a_wen     (a_wen),
        .b_in      (b_in),
        .b_addr    (b_addr),
        .b_wen     (b_wen),
        .mm_start  (mm_start),
        .mm_done   (mm_done),
        .busy      (busy),
        .job_count (job_count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every write must match the next element the bench handed over.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_wen && b_wen) check("wen_exclusive", 32'd1, 32'd0);
            if (a_wen || b_wen) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {b_wen, b_wen ? b_addr : a_addr, b_wen ? b_in : a_in}, 32'h1FFFF);
                end else begin
                    logic [12:0] e;
                    e = exp_q.pop_front();
                    check("write_port", {b_wen, b_wen ? b_addr : a_addr, b_wen ? b_in : a_in}, e);
                end
                if (a_wen && a_addr < 9) cap_a[a_addr] = a_in;
                if (b_wen && b_addr < 9) cap_b[b_addr] = b_in;
            end
        end
    end

    // Behavioural multiplier: computes C from captured memories, then done handshake.
    initial begin
        mm_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && mm_start && !mm_done) begin
                for (int r = 0; r < M; r++)
                    for (int c = 0; c < P; c++) begin
                        int acc;
                        acc = 0;
                        for (int k = 0; k < N; k++)
                            acc += int'($signed(cap_a[r*N+k])) * int'($signed(cap_b[k*P+c]));
                        mult_c[r*P+c] = acc[15:0];
                    end
                repeat (3) @(negedge clk);
                mm_done = 1'b1;
                for (int t = 0; t < 32 && mm_start; t++) @(negedge clk);
                repeat (2) @(negedge clk);
                mm_done = 1'b0;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_a_wen"}, a_wen, 0);
        check({tag, "_b_wen"}, b_wen, 0);
        check({tag, "_a_in"}, a_in, 0);
        check({tag, "_b_in"}, b_in, 0);
        check({tag, "_a_addr"}, a_addr, 0);
        check({tag, "_b_addr"}, b_addr, 0);
        check({tag, "_mm_start"}, mm_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_job_count"}, job_count, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // One complete job from ja/jb; optionally with bubbles, or holding 0x7F for the next job.
    task automatic run_job(input bit bubbles, input bit hold_next, input bit pre_taken);
        int tmo;
        for (int i = (pre_taken ? 1 : 0); i < 18; i++) begin
            logic [7:0] d;
            @(negedge clk);
            if (bubbles) begin
                repeat ($urandom_range(2, 0)) begin
                    s_valid = 1'b0;
                    s_data  = 8'($urandom);
                    @(negedge clk);
                end
            end
            d       = (i < 9) ? ja[i] : jb[i-9];
            s_valid = 1'b1;
            s_data  = d;
            s_last  = (i == 17);
            check("s_ready_load", s_ready, 1);
            exp_q.push_back({(i >= 9), 4'((i < 9) ? i : i - 9), d});
        end
        @(negedge clk);
        s_valid = hold_next;
        s_data  = hold_next ? 8'h7F : 8'($urandom);
        s_last  = 1'b0;
        check("settle_s_ready", s_ready, 0);
        check("settle_busy", busy, 1);
        check("gap1_mm_start", mm_start, 0);
        @(negedge clk);
        check("gap2_mm_start", mm_start, 0);
        @(negedge clk);
        check("start_mm_start", mm_start, 1);
        check("wait_s_ready", s_ready, 0);
        exp_jobs++;
        tmo = 0;
        while (!s_ready && tmo < 64) begin
            @(negedge clk);
            tmo++;
        end
        check("release_timeout", (tmo < 64), 1);
        if (hold_next) exp_q.push_back({1'b0, 4'd0, 8'h7F});
        else s_valid = 1'b0;
        check("job_count", job_count, exp_jobs);
        check("mm_start_low", mm_start, 0);
        check("busy_idle", busy, 0);
        check("err_clear_nomacro", err, 0);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < P; c++) begin
                int acc;
                acc = 0;
                for (int k = 0; k < N; k++)
                    acc += int'($signed(ja[r*N+k])) * int'($signed(jb[k*P+c]));
                check("c_out", mult_c[r*P+c], acc[15:0]);
            end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_s_ready", s_ready, 1);

        // Reset in the middle of LOAD_B after 12 transfers.
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            @(negedge clk);
            d       = 8'($urandom);
            s_valid = 1'b1;
            s_data  = d;
            check("partial_s_ready", s_ready, 1);
            exp_q.push_back({(i >= 9), 4'((i < 9) ? i : i - 9), d});
        end
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_values("mid_job");
        check("mid_job_pending", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_job_s_ready", s_ready, 1);

        // A = 1..9, B = identity.
        for (int i = 0; i < 9; i++) begin
            ja[i] = 8'(i + 1);
            jb[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
        end
        run_job(1'b0, 1'b0, 1'b0);
        check("identity_c0", mult_c[0], 16'd1);
        check("identity_c8", mult_c[8], 16'd9);

        // Random data with bubbles.
        for (int i = 0; i < 9; i++) begin
            ja[i] = 8'($urandom);
            jb[i] = 8'($urandom);
        end
        run_job(1'b1, 1'b0, 1'b0);

        // Backpressure: 0x7F held during WAIT_DONE becomes A[0] of the next job.
        for (int i = 0; i < 9; i++) begin
            ja[i] = 8'($urandom);
            jb[i] = 8'($urandom);
        end
        run_job(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            ja[i] = 8'($urandom);
            jb[i] = 8'($urandom);
        end
        ja[0] = 8'h7F;
        run_job(1'b1, 1'b0, 1'b1);

        // Signed extremes.
        for (int i = 0; i < 9; i++) begin
            ja[i] = 8'h80;
            jb[i] = 8'h80;
        end
        run_job(1'b0, 1'b0, 1'b0);
        check("extreme_c0", mult_c[0], 16'hC000);
        check("extreme_c4", mult_c[4], 16'hC000);

`ifdef LOADER_LAST_CHECK_EN
        // Framing error on element 10, then a well-framed job.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_jobs = 0;
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            @(negedge clk);
            d       = 8'($urandom);
            s_valid = 1'b1;
            s_data  = d;
            s_last  = (i == 9);
            exp_q.push_back({(i >= 9), 4'((i < 9) ? i : i - 9), d});
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("frame_err", err, 1);
        check("frame_s_ready", s_ready, 1);
        repeat (4) begin
            @(negedge clk);
            check("frame_no_start", mm_start, 0);
        end
        for (int i = 0; i < 9; i++) begin
            ja[i] = 8'($urandom);
            jb[i] = 8'($urandom);
        end
        run_job(1'b0, 1'b0, 1'b0);
        check("frame_err_sticky", err, 1);
`endif

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
